// File: rtl/exe_result_pkg.sv
// Shared types and defaults for the execute-result stage: FSM states, widths,
// the r0 constant and the buffered entry record.
package exe_result_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  localparam logic [REG_ADDR_WIDTH_DEF-1:0] REG_R0 = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]     result;
    logic [REG_ADDR_WIDTH_DEF-1:0] destReg;
    logic                          writeEnable;
  } entry_t;

  // r0 is hard-zero, so a write to it is squashed at capture time.
  function automatic entry_t makeEntry(input logic [DATA_WIDTH_DEF-1:0]     result,
                                       input logic [REG_ADDR_WIDTH_DEF-1:0] destReg,
                                       input logic                          writeEnable);
    entry_t e;
    e.result      = result;
    e.destReg     = destReg;
    e.writeEnable = writeEnable & (destReg != REG_R0);
    return e;
  endfunction

endpackage

// File: rtl/exe_fwd_match.sv
// Operand-forwarding match for one read port: r0 never hits and the younger
// SKID entry takes priority over MAIN.
module exe_fwd_match
  import exe_result_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] fwdAddr,
  input  logic                      mainValid,
  input  logic                      mainWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] mainDestReg,
  input  logic [DATA_WIDTH-1:0]     mainResult,
  input  logic                      skidValid,
  input  logic                      skidWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] skidDestReg,
  input  logic [DATA_WIDTH-1:0]     skidResult,
  output logic                      fwdHit,
  output logic [DATA_WIDTH-1:0]     fwdData
);

  logic addrLive;
  logic mainHit;
  logic skidHit;

  assign addrLive = (fwdAddr != '0);
  assign mainHit  = addrLive & mainValid & mainWriteEnable & (mainDestReg == fwdAddr);
  assign skidHit  = addrLive & skidValid & skidWriteEnable & (skidDestReg == fwdAddr);

  always_comb begin
    fwdHit  = mainHit | skidHit;
    fwdData = '0;
    if (skidHit) begin
      fwdData = skidResult;
    end else if (mainHit) begin
      fwdData = mainResult;
    end
  end

endmodule

// File: rtl/exe_result_stage.sv
// Execute-to-writeback result buffer with operand forwarding for two ports.
// EXE_RESULT_SKID_EN selects the 2-entry skid with registered inReady.
module exe_result_stage
  import exe_result_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      flush,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [DATA_WIDTH-1:0]     inResult,
  input  logic [REG_ADDR_WIDTH-1:0] inDestReg,
  input  logic                      inWriteEnable,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_WIDTH-1:0]     outResult,
  output logic [REG_ADDR_WIDTH-1:0] outDestReg,
  output logic                      outWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] fwdAddrA,
  output logic                      fwdHitA,
  output logic [DATA_WIDTH-1:0]     fwdDataA,
  input  logic [REG_ADDR_WIDTH-1:0] fwdAddrB,
  output logic                      fwdHitB,
  output logic [DATA_WIDTH-1:0]     fwdDataB
);

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t inEntry;
  entry_t skidView;
  logic   push, pop, mainValid, skidValid;

  assign inEntry   = makeEntry(inResult, inDestReg, inWriteEnable);
  assign mainValid = (state_q != ST_EMPTY);
  assign push      = inValid & inReady;
  assign pop       = mainValid & outReady;

  assign outValid       = mainValid;
  assign outResult      = main_q.result;
  assign outDestReg     = main_q.destReg;
  assign outWriteEnable = main_q.writeEnable;

`ifdef EXE_RESULT_SKID_EN
  entry_t skid_q, skid_d;
  logic   inReady_q, inReady_d;

  assign skidValid = (state_q == ST_TWO);
  assign skidView  = skid_q;
  assign inReady   = inReady_q;
`else
  // Without the skid, ready depends on the downstream handshake directly.
  assign skidValid = 1'b0;
  assign skidView  = '0;
  assign inReady   = ~mainValid | outReady;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EXE_RESULT_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d            = ST_EMPTY;
      main_d.writeEnable = 1'b0;
`ifdef EXE_RESULT_SKID_EN
      skid_d.writeEnable = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = inEntry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
`ifdef EXE_RESULT_SKID_EN
          if (push && pop) begin
            main_d = inEntry;
          end else if (push) begin
            skid_d  = inEntry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
`else
          if (push) begin
            main_d = inEntry;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
`endif
        end
`ifdef EXE_RESULT_SKID_EN
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
`ifdef EXE_RESULT_SKID_EN
    inReady_d = (state_d != ST_TWO);
`endif
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
`ifdef EXE_RESULT_SKID_EN
      skid_q    <= '0;
      inReady_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
`ifdef EXE_RESULT_SKID_EN
      skid_q    <= skid_d;
      inReady_q <= inReady_d;
`endif
    end
  end

  exe_fwd_match #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdA (
    .fwdAddr         (fwdAddrA),
    .mainValid       (mainValid),
    .mainWriteEnable (main_q.writeEnable),
    .mainDestReg     (main_q.destReg),
    .mainResult      (main_q.result),
    .skidValid       (skidValid),
    .skidWriteEnable (skidView.writeEnable),
    .skidDestReg     (skidView.destReg),
    .skidResult      (skidView.result),
    .fwdHit          (fwdHitA),
    .fwdData         (fwdDataA)
  );

  exe_fwd_match #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdB (
    .fwdAddr         (fwdAddrB),
    .mainValid       (mainValid),
    .mainWriteEnable (main_q.writeEnable),
    .mainDestReg     (main_q.destReg),
    .mainResult      (main_q.result),
    .skidValid       (skidValid),
    .skidWriteEnable (skidView.writeEnable),
    .skidDestReg     (skidView.destReg),
    .skidResult      (skidView.result),
    .fwdHit          (fwdHitB),
    .fwdData         (fwdDataB)
  );

endmodule

// File: tb/tb_exe_result_stage.sv
// Scoreboard bench for exe_result_stage: a FIFO reference model drives
// expectations, a negedge monitor checks every accepted writeback entry.
module tb_exe_result_stage;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
  } ent_t;

`ifdef EXE_RESULT_SKID_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inResult = '0;
  logic [4:0]  inDestReg = '0;
  logic        inWriteEnable = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outResult;
  logic [4:0]  outDestReg;
  logic        outWriteEnable;
  logic [4:0]  fwdAddrA = '0;
  logic        fwdHitA;
  logic [31:0] fwdDataA;
  logic [4:0]  fwdAddrB = '0;
  logic        fwdHitB;
  logic [31:0] fwdDataB;

  int checks = 0;
  int errors = 0;

  ent_t modelQ[$];
  ent_t sbQ[$];

  exe_result_stage dut (
    .clock          (clock),
    .nReset         (nReset),
    .flush          (flush),
    .inValid        (inValid),
    .inReady        (inReady),
    .inResult       (inResult),
    .inDestReg      (inDestReg),
    .inWriteEnable  (inWriteEnable),
    .outValid       (outValid),
    .outReady       (outReady),
    .outResult      (outResult),
    .outDestReg     (outDestReg),
    .outWriteEnable (outWriteEnable),
    .fwdAddrA       (fwdAddrA),
    .fwdHitA        (fwdHitA),
    .fwdDataA       (fwdDataA),
    .fwdAddrB       (fwdAddrB),
    .fwdHitB        (fwdHitB),
    .fwdDataB       (fwdDataB)
  );

  always #5 clock = ~clock;

  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest buffered writer of the register wins; r0 is never forwarded.
  function automatic void fwdModel(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != 5'd0) begin
      for (int i = 0; i < modelQ.size(); i++) begin
        if (modelQ[i].we && modelQ[i].dest == addr) begin
          hit  = 1'b1;
          data = modelQ[i].res;
        end
      end
    end
  endfunction

  function automatic logic modelReady();
`ifdef EXE_RESULT_SKID_EN
    return modelQ.size() < CAPACITY;
`else
    return (modelQ.size() == 0) || outReady;
`endif
  endfunction

  task automatic checkOutput();
    logic        hit;
    logic [31:0] data;
    compareField("outValid", 32'(outValid), 32'(modelQ.size() > 0));
    compareField("inReady", 32'(inReady), 32'(modelReady()));
    if (modelQ.size() > 0) begin
      compareField("outResult", outResult, modelQ[0].res);
      compareField("outDestReg", 32'(outDestReg), 32'(modelQ[0].dest));
      compareField("outWriteEnable", 32'(outWriteEnable), 32'(modelQ[0].we));
    end
    fwdModel(fwdAddrA, hit, data);
    compareField("fwdHitA", 32'(fwdHitA), 32'(hit));
    compareField("fwdDataA", fwdDataA, data);
    fwdModel(fwdAddrB, hit, data);
    compareField("fwdHitB", 32'(fwdHitB), 32'(hit));
    compareField("fwdDataB", fwdDataB, data);
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, updates model at posedge.
  task automatic applyStimulus(input logic v, input logic [31:0] res, input logic [4:0] dest,
                               input logic we, input logic oRdy, input logic fl,
                               input logic [4:0] fa, input logic [4:0] fb);
    logic doPush, doPop;
    ent_t e;
    inValid = v; inResult = res; inDestReg = dest; inWriteEnable = we;
    outReady = oRdy; flush = fl; fwdAddrA = fa; fwdAddrB = fb;
    @(negedge clock);
    checkOutput();
    doPush = v && modelReady() && !fl;
    doPop  = (modelQ.size() > 0) && oRdy && !fl;
    e.res = res; e.dest = dest; e.we = we && (dest != 5'd0);
    @(posedge clock);
    if (fl) begin
      modelQ.delete();
      sbQ.delete();
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (doPush) begin
        modelQ.push_back(e);
        sbQ.push_back(e);
      end
    end
    #1;
  endtask

  // Monitor: every handshake-accepted writeback entry must match the oldest expectation.
  always @(negedge clock) begin
    if (nReset && outValid && outReady && !flush) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL monitorUnexpected actual=%h expected=none at %0t", outResult, $time);
      end else begin
        compareField("monResult", outResult, sbQ[0].res);
        compareField("monDestReg", 32'(outDestReg), 32'(sbQ[0].dest));
        compareField("monWriteEnable", 32'(outWriteEnable), 32'(sbQ[0].we));
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    fwdAddrA = 5'd3;
    fwdAddrB = 5'd5;
    #12;
    compareField("rstOutValid", 32'(outValid), 32'd0);
    compareField("rstInReady", 32'(inReady), 32'd1);
    compareField("rstOutResult", outResult, 32'd0);
    compareField("rstOutDestReg", 32'(outDestReg), 32'd0);
    compareField("rstOutWe", 32'(outWriteEnable), 32'd0);
    compareField("rstFwdHitA", 32'(fwdHitA), 32'd0);
    compareField("rstFwdHitB", 32'(fwdHitB), 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] basic capture");
    applyStimulus(1, 32'hDEADBEEF, 5'd3, 1, 1, 0, 5'd3, 5'd4);
    applyStimulus(0, 32'h0, 5'd0, 0, 1, 0, 5'd3, 5'd4);

    $display("[TB] back-pressure ordering");
    applyStimulus(1, 32'h11, 5'd7, 1, 0, 0, 5'd7, 5'd8);
    applyStimulus(1, 32'h22, 5'd8, 1, 0, 0, 5'd7, 5'd8);
    applyStimulus(1, 32'h33, 5'd9, 1, 0, 0, 5'd7, 5'd8);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 5'd0, 0, 1, 0, 5'd7, 5'd8);

    $display("[TB] r0 write squash");
    applyStimulus(1, 32'h55, 5'd0, 1, 0, 0, 5'd0, 5'd0);
    applyStimulus(0, 32'h0, 5'd0, 0, 0, 0, 5'd0, 5'd0);
    applyStimulus(0, 32'h0, 5'd0, 0, 1, 0, 5'd0, 5'd0);

    $display("[TB] forwarding priority");
    applyStimulus(1, 32'h100, 5'd5, 1, 0, 0, 5'd5, 5'd6);
    applyStimulus(1, 32'h200, 5'd5, 1, 0, 0, 5'd5, 5'd6);
    applyStimulus(0, 32'h0, 5'd0, 0, 0, 0, 5'd5, 5'd6);

    $display("[TB] flush while full");
    applyStimulus(1, 32'h300, 5'd6, 1, 1, 1, 5'd5, 5'd6);
    compareField("flushOutValid", 32'(outValid), 32'd0);
    compareField("flushInReady", 32'(inReady), 32'd1);
    compareField("flushOutWe", 32'(outWriteEnable), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 5'd0, 0, 1, 0, 5'd5, 5'd6);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 32'hA1, 5'd1, 1, 0, 0, 5'd1, 5'd2);
    applyStimulus(1, 32'hA2, 5'd2, 1, 0, 0, 5'd1, 5'd2);
    inValid = 1'b0;
    outReady = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    compareField("asyncOutValid", 32'(outValid), 32'd0);
    compareField("asyncInReady", 32'(inReady), 32'd1);
    compareField("asyncOutResult", outResult, 32'd0);
    compareField("asyncFwdHitA", 32'(fwdHitA), 32'd0);
    modelQ.delete();
    sbQ.delete();
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 19) == 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 5'd0, 0, 1, 0, 5'd0, 5'd0);
    compareField("drainModel", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
